// File: rtl/noc_port_arbiter_pkg.sv
// noc_arb_pkg: shared types, defaults and priority helper for the NOC port arbiter.
package noc_arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int MAX_FLITS_DEF = 16;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    // An out-of-range index leaves the current priority untouched.
    function automatic logic [31:0] rotl_onehot(input logic [31:0] prio, input int unsigned idx,
                                                input int unsigned n = NUM_REQ_DEF);
        return (idx >= n) ? prio : (32'd1 << ((idx + 1) % n));
    endfunction
endpackage

// File: rtl/noc_port_arbiter_if.sv
// noc_port_arbiter_if: requester/downstream handshake bundle of one router output port.
import noc_arb_pkg::*;
interface noc_port_arbiter_if #(parameter int NUM_REQ = NUM_REQ_DEF);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] tail_i;
    logic               out_ready_i;
    logic [NUM_REQ-1:0] grant_o;
    logic               fire_o;
    logic               busy_o;
    logic               timeout_o;
    logic [NUM_REQ-1:0] priority_order_o;
    modport master (output req_i, tail_i, out_ready_i,
                    input grant_o, fire_o, busy_o, timeout_o, priority_order_o);
    modport slave (input req_i, tail_i, out_ready_i,
                   output grant_o, fire_o, busy_o, timeout_o, priority_order_o);
endinterface

// File: rtl/noc_port_arbiter_rr_select.sv
// rr_select: one-hot round-robin pick of the first request at or above the priority bit, with wrap.
import noc_arb_pkg::*;
module rr_select #(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] prio,
    output logic [NUM_REQ-1:0] gnt
);
    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] dbl_gnt;
    // Subtracting the priority bit clears everything below it in the doubled vector.
    always_comb begin
        dbl_req = {req, req};
        dbl_gnt = dbl_req & ~(dbl_req - {{NUM_REQ{1'b0}}, prio});
        gnt = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];
    end
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: wormhole round-robin arbiter holding one output port per packet, with flit watchdog.
import noc_arb_pkg::*;
module noc_port_arbiter #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int MAX_FLITS = MAX_FLITS_DEF
) (
    input logic clk,
    input logic reset,
    noc_port_arbiter_if.slave port
);
    localparam int CNT_W = $clog2(MAX_FLITS);
    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, prio_q, prio_d, winner;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, timeout_q, timeout_d, fire, tail_w, last_flit;
    int unsigned        w_idx;

    rr_select #(.NUM_REQ(NUM_REQ)) u_sel (.req(port.req_i), .prio(prio_q), .gnt(winner));

    always_comb begin
        w_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) w_idx = i;
        fire = (state_q == ARB_BUSY) & |(port.req_i & grant_q) & port.out_ready_i;
        tail_w = |(port.tail_i & grant_q);
        last_flit = cnt_q == CNT_W'(MAX_FLITS - 1);
        state_d = state_q;
        grant_d = grant_q;
        prio_d = prio_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        timeout_d = 1'b0;
        if (state_q == ARB_IDLE && |port.req_i) begin
            state_d = ARB_BUSY;
            grant_d = winner;
            busy_d = 1'b1;
            cnt_d = '0;
        end else if (fire && (tail_w || last_flit)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d = 1'b0;
            timeout_d = !tail_w;
            prio_d = NUM_REQ'(rotl_onehot(32'(prio_q), w_idx, NUM_REQ));
        end else if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            prio_q <= NUM_REQ'(1);
            cnt_q <= '0;
            busy_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q <= prio_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign port.grant_o = grant_q;
    assign port.fire_o = fire;
    assign port.busy_o = busy_q;
    assign port.timeout_o = timeout_q;
    assign port.priority_order_o = prio_q;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed checks of arbitration, wormhole hold, rotation, watchdog and reset.
module tb_noc_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int fires;

    noc_port_arbiter_if #(.NUM_REQ(4)) bus ();
    noc_port_arbiter #(.NUM_REQ(4), .MAX_FLITS(16)) dut (.clk(clk), .reset(reset), .port(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic rdy);
        bus.req_i = r;
        bus.tail_i = t;
        bus.out_ready_i = rdy;
        #1;
    endtask

    logic [3:0] t3_req [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    logic [3:0] t3_tail[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic       t3_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       t3_fire[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_grant", 32'(bus.grant_o), 32'h0);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'h0);
        chk("rst_prio", 32'(bus.priority_order_o), 32'h1);
        chk("idle_fire", 32'(bus.fire_o), 32'h0);

        drive(4'b1010, 4'b1010, 1'b1);
        tick();
        chk("t1_grant_a", 32'(bus.grant_o), 32'h2);
        chk("t1_busy", 32'(bus.busy_o), 32'h1);
        chk("t1_fire", 32'(bus.fire_o), 32'h1);
        tick();
        chk("t1_rel_a", 32'(bus.grant_o), 32'h0);
        chk("t1_prio_a", 32'(bus.priority_order_o), 32'h4);
        tick();
        chk("t1_grant_b", 32'(bus.grant_o), 32'h8);
        tick();
        chk("t1_prio_b", 32'(bus.priority_order_o), 32'h1);
        drive(4'b0000, 4'b0000, 1'b1);

        drive(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_grant", 32'(bus.grant_o), 32'd1 << (k % 4));
            tick();
            chk("t2_idle", 32'(bus.grant_o), 32'h0);
            chk("t2_prio", 32'(bus.priority_order_o), 32'd1 << ((k + 1) % 4));
        end
        drive(4'b0000, 4'b0000, 1'b1);

        drive(4'b0100, 4'b0000, 1'b1);
        tick();
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            drive(t3_req[c], t3_tail[c], t3_rdy[c]);
            chk("t3_fire", 32'(bus.fire_o), 32'(t3_fire[c]));
            chk("t3_grant", 32'(bus.grant_o), 32'h4);
            if (bus.fire_o) fires++;
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b1);
        chk("t3_nfire", 32'(fires), 32'd3);
        chk("t3_rel", 32'(bus.grant_o), 32'h0);
        chk("t3_busy", 32'(bus.busy_o), 32'h0);
        chk("t3_prio", 32'(bus.priority_order_o), 32'h8);
        chk("t3_timeout", 32'(bus.timeout_o), 32'h0);

        drive(4'b0010, 4'b0000, 1'b1);
        tick();
        chk("t4_grant", 32'(bus.grant_o), 32'h2);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t4_hold", 32'(bus.busy_o), 32'h1);
            chk("t4_no_to", 32'(bus.timeout_o), 32'h0);
        end
        tick();
        drive(4'b0000, 4'b0000, 1'b1);
        chk("t4_timeout", 32'(bus.timeout_o), 32'h1);
        chk("t4_busy", 32'(bus.busy_o), 32'h0);
        chk("t4_grant0", 32'(bus.grant_o), 32'h0);
        chk("t4_prio", 32'(bus.priority_order_o), 32'h4);
        tick();
        chk("t4_pulse", 32'(bus.timeout_o), 32'h0);

        drive(4'b1000, 4'b0000, 1'b1);
        tick();
        chk("t5_grant", 32'(bus.grant_o), 32'h8);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_grant0", 32'(bus.grant_o), 32'h0);
        chk("t5_busy", 32'(bus.busy_o), 32'h0);
        chk("t5_prio", 32'(bus.priority_order_o), 32'h1);
        chk("t5_timeout", 32'(bus.timeout_o), 32'h0);
        tick();
        chk("t5_rearb", 32'(bus.grant_o), 32'h8);
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b1);
        chk("t5_prio_end", 32'(bus.priority_order_o), 32'h1);

        drive(4'b0001, 4'b0000, 1'b1);
        tick();
        chk("t6_grant", 32'(bus.grant_o), 32'h1);
        drive(4'b1111, 4'b1110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_fire", 32'(bus.fire_o), 32'h1);
            tick();
            chk("t6_hold", 32'(bus.grant_o), 32'h1);
        end
        drive(4'b1111, 4'b1111, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b1);
        chk("t6_rel", 32'(bus.grant_o), 32'h0);
        chk("t6_prio", 32'(bus.priority_order_o), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Wormhole round-robin arbiter for one NOC router output port.
- Shares the port between NUM_REQ input requesters and grants one requester for a whole packet.
- Holds the grant until that requester's tail flit transfers, then rotates the one-hot priority order so the next requester after the winner has highest priority.
- Includes a flit-count watchdog that force-releases a packet that never delivers its tail.

Parameters:
NUM_REQ, 4, number of requesters; sets the width of req/tail/grant/priority.
MAX_FLITS, 16, maximum flits per packet before forced release; must be >= 2.
CNT_W, $clog2(MAX_FLITS), width of the flit counter; derived, never overridden.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req_i  input  NUM_REQ  per-requester request; bit k high = requester k has a flit for this port.
tail_i  input  NUM_REQ  bit k high = requester k's current flit is its packet tail; qualified by req_i[k].
out_ready_i  input  1  downstream can accept a flit this cycle.
grant_o  output  NUM_REQ  one-hot registered grant; all-zero when idle.
fire_o  output  1  combinational; high in a cycle where a flit transfers.
busy_o  output  1  registered; high while a packet owns the port.
timeout_o  output  1  registered one-cycle pulse on a forced release.
priority_order_o  output  NUM_REQ  current one-hot priority; the set bit marks the highest-priority requester.

Behaviour:
- Reset:
  - Synchronous, active-high; reset is sampled on the clk edge.
  - Results: state ARB_IDLE, grant_o=0, busy_o=0, timeout_o=0, flit counter=0, priority_order_o=4'b0001 (one-hot bit 0 for general NUM_REQ).
  - Reset mid-packet aborts the packet with no timeout pulse.
- States: ARB_IDLE, ARB_BUSY.
- ARB_IDLE:
  - If req_i != 0, pick the winner: the first set req bit found by scanning upward, with wrap, starting at the priority_order_o bit.
  - Next cycle: grant_o = one-hot winner, busy_o=1, counter=0, state ARB_BUSY.
  - Arbitration latency is one cycle from req to grant.
  - If req_i == 0, stay in ARB_IDLE.
- ARB_BUSY, with w = the granted index:
  - fire_o = req_i[w] & out_ready_i; fire_o is 0 in ARB_IDLE.
  - On fire with tail_i[w]=1 (normal release): next cycle grant_o=0, busy_o=0, state ARB_IDLE, priority_order_o = one-hot (w+1) mod NUM_REQ.
  - On fire with tail_i[w]=0: if counter == MAX_FLITS-1, force release with the same next-state as a normal release, plus timeout_o=1 for one cycle. Otherwise counter++.
  - req_i[w] deasserting mid-packet does not release the grant; the port stays owned and no flit fires.
  - Requests from other requesters and their tail bits are ignored while busy.
- Back-to-back packets: every release returns through ARB_IDLE, so there is exactly one idle cycle between packets.
- out_ready_i low: no fire, counter holds, grant holds indefinitely; the watchdog counts flits, not cycles.
- Single-flit packet (tail on the first fire): legal; counter is never incremented.
- priority_order_o changes only on a release and is always one-hot.

Decomposition:
- Package noc_arb_pkg holds:
  - NUM_REQ_DEF=4 and MAX_FLITS_DEF=16.
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
  - Function rotl_onehot(prio, idx), which returns the one-hot value of (idx+1) mod NUM_REQ.
- One combinational sub-module, rr_select: inputs req and one-hot priority; output is the one-hot winner, all-zero if req==0.
- The top module holds the FSM, grant register, counter and priority register.

Test Plan:
- Reset, then req_i=4'b1010, single-flit packets (tail_i=req_i), out_ready_i=1 -> grant 4'b0010 one cycle after req, then priority 4'b0100; after one idle cycle grant 4'b1000, then priority 4'b0001.
- All four requesting continuously with single-flit packets -> grant order 0,1,2,3,0, each grant separated by one idle cycle; priority_order_o walks 0010,0100,1000,0001.
- Requester 2 sends a 3-flit packet with out_ready_i low for 2 cycles after flit 1 and req_i[2] dropped for 1 cycle -> grant stays 4'b0100 throughout; exactly 3 fire_o pulses; release after the tail.
- Requester 1 sends 16 flits with no tail, MAX_FLITS=16 -> forced release on the 16th fire; timeout_o high exactly one cycle; busy_o drops; priority 4'b0100.
- reset asserted while requester 3 is mid-packet -> next cycle grant_o=0, busy_o=0, priority 4'b0001, timeout_o=0; re-arbitration starts once reset is low.
- Requester 0 busy with a packet while req_i=4'b1111 and tail_i=4'b1110 -> tails from other requesters are ignored; the grant is released only on tail_i[0].
